// File: rtl/spi_pkg.sv
// Shared types for the SPI slave: frame FSM states.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } spi_state_t;

endpackage

// File: rtl/spi_slave_sync_sync2.sv
// Two-flop synchronizer for one asynchronous bit.
// No reset: the chain keeps tracking its input through reset, so a cs_n that
// stays low across reset is never mistaken for a new falling edge.
module sync2 (
  input  logic clk,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    meta <= d;
    q    <= meta;
  end

endmodule

// File: rtl/spi_slave_sync.sv
// SPI slave oversampled in the clk domain: synchronized sck/cs_n/sdo, edge
// detection, frame FSM, tx holding register and rx word output.
module spi_slave_sync
  import spi_pkg::*;
#(
  parameter int unsigned WIDTH     = 10,
  parameter bit          CPOL      = 1'b0,
  parameter bit          CPHA      = 1'b0,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sck,
  input  logic             cs_n,
  input  logic             sdo,
  output logic             sdi,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             frame_err,
  output logic             underrun
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic sck_s, cs_s, sdo_s;
  logic sck_d, cs_d;

  sync2 u_sync_sck (.clk(clk), .d(sck),  .q(sck_s));
  sync2 u_sync_cs  (.clk(clk), .d(cs_n), .q(cs_s));
  sync2 u_sync_sdo (.clk(clk), .d(sdo),  .q(sdo_s));

  // Third stage for edge detection; unreset for the same reason as sync2.
  always_ff @(posedge clk) begin
    sck_d <= sck_s;
    cs_d  <= cs_s;
  end

  logic cs_fall, cs_rise, lead, trail, samp_edge, shift_edge;

  assign cs_fall    = cs_d & ~cs_s;
  assign cs_rise    = ~cs_d & cs_s;
  assign lead       = (sck_d == CPOL) && (sck_s != CPOL);
  assign trail      = (sck_d != CPOL) && (sck_s == CPOL);
  assign samp_edge  = CPHA ? trail : lead;
  assign shift_edge = CPHA ? lead : trail;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  spi_state_t       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] tx_sr;
  logic [WIDTH-1:0] rx_sr;
  logic [WIDTH-1:0] hold;
  logic [WIDTH-1:0] rx_next;
  logic [WIDTH-1:0] load_word;
  logic             accept;

  assign rx_next   = MSB_FIRST ? {rx_sr[WIDTH-2:0], sdo_s} : {sdo_s, rx_sr[WIDTH-1:1]};
  assign load_word = tx_ready ? '0 : hold;
  assign accept    = tx_valid & tx_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      hold      <= '0;
      rx_data   <= '0;
      tx_ready  <= 1'b1;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      underrun  <= 1'b0;
      sdi       <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      underrun  <= 1'b0;

      if (accept) begin
        hold     <= tx_data;
        tx_ready <= 1'b0;
      end

      case (state)
        IDLE: begin
          sdi <= 1'b0;
          // Frame start uses the old holding value; a coincident write is kept for the next frame.
          if (cs_fall) begin
            state    <= SHIFT;
            cnt      <= '0;
            rx_sr    <= '0;
            underrun <= tx_ready;
            tx_ready <= ~accept;
            if (CPHA) begin
              tx_sr <= load_word;
              sdi   <= 1'b0;
            end else begin
              tx_sr <= shift_out(load_word);
              sdi   <= first_bit(load_word);
            end
          end
        end

        SHIFT: begin
          if (cs_rise) begin
            state     <= IDLE;
            frame_err <= 1'b1;
            sdi       <= 1'b0;
          end else begin
            if (shift_edge) begin
              sdi   <= first_bit(tx_sr);
              tx_sr <= shift_out(tx_sr);
            end
            if (samp_edge) begin
              rx_sr <= rx_next;
              cnt   <= cnt + CW'(1);
              if (cnt == CW'(WIDTH - 1)) begin
                state    <= DONE;
                rx_data  <= rx_next;
                rx_valid <= 1'b1;
                sdi      <= 1'b0;
              end
            end
          end
        end

        DONE: begin
          sdi <= 1'b0;
          if (cs_rise) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_sync.sv
// Bench for spi_slave_sync: a mode-0 10-bit MSB-first instance and a
// mode-3 16-bit LSB-first instance, with an rx-word scoreboard per instance.
module tb_spi_slave_sync;

  logic clk, reset;

  logic        sck_a, cs_n_a, sdo_a, sdi_a, tx_valid_a, tx_ready_a, rx_valid_a, frame_err_a, underrun_a;
  logic [9:0]  tx_data_a, rx_data_a;
  logic        sck_b, cs_n_b, sdo_b, sdi_b, tx_valid_b, tx_ready_b, rx_valid_b, frame_err_b, underrun_b;
  logic [15:0] tx_data_b, rx_data_b;

  int n_checks = 0;
  int n_fails  = 0;
  int rxv_a = 0, ferr_a = 0, urun_a = 0;
  int rxv_b = 0, ferr_b = 0, urun_b = 0;

  logic [9:0]  exp_a[$];
  logic [15:0] exp_b[$];

  spi_slave_sync #(.WIDTH(10), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .reset(reset), .sck(sck_a), .cs_n(cs_n_a), .sdo(sdo_a), .sdi(sdi_a),
    .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
    .rx_data(rx_data_a), .rx_valid(rx_valid_a), .frame_err(frame_err_a), .underrun(underrun_a)
  );

  spi_slave_sync #(.WIDTH(16), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .reset(reset), .sck(sck_b), .cs_n(cs_n_b), .sdo(sdo_b), .sdi(sdi_b),
    .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
    .rx_data(rx_data_b), .rx_valid(rx_valid_b), .frame_err(frame_err_b), .underrun(underrun_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters and rx scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    logic [9:0]  ea;
    logic [15:0] eb;
    if (frame_err_a) ferr_a++;
    if (underrun_a)  urun_a++;
    if (frame_err_b) ferr_b++;
    if (underrun_b)  urun_b++;
    if (rx_valid_a) begin
      rxv_a++;
      n_checks++;
      if (exp_a.size() == 0) begin
        n_fails++;
        $display("FAIL sb_a_unexpected: got rx_data %h, required no word", rx_data_a);
      end else begin
        ea = exp_a.pop_front();
        if (rx_data_a !== ea) begin
          n_fails++;
          $display("FAIL sb_a_word: got %h, required %h", rx_data_a, ea);
        end
      end
    end
    if (rx_valid_b) begin
      rxv_b++;
      n_checks++;
      if (exp_b.size() == 0) begin
        n_fails++;
        $display("FAIL sb_b_unexpected: got rx_data %h, required no word", rx_data_b);
      end else begin
        eb = exp_b.pop_front();
        if (rx_data_b !== eb) begin
          n_fails++;
          $display("FAIL sb_b_word: got %h, required %h", rx_data_b, eb);
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic load_a(input logic [9:0] w);
    int k;
    k = 0;
    @(negedge clk);
    tx_data_a  = w;
    tx_valid_a = 1'b1;
    while (tx_ready_a !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    n_checks++;
    if (k >= 20) begin n_fails++; $display("FAIL load_a_handshake: tx_ready %b, required 1", tx_ready_a); end
    @(negedge clk);
    tx_valid_a = 1'b0;
  endtask

  task automatic load_b(input logic [15:0] w);
    int k;
    k = 0;
    @(negedge clk);
    tx_data_b  = w;
    tx_valid_b = 1'b1;
    while (tx_ready_b !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    n_checks++;
    if (k >= 20) begin n_fails++; $display("FAIL load_b_handshake: tx_ready %b, required 1", tx_ready_b); end
    @(negedge clk);
    tx_valid_b = 1'b0;
  endtask

  // Mode-0 MSB-first master; optional tx write aligned with the synchronized cs_n fall,
  // optional reset pulse before cs_n is released.
  task automatic frame_a(input logic [9:0] mosi, input int nbits, input bit coin,
                         input logic [9:0] cw, input bit rst_mid, output logic [9:0] miso);
    int k;
    miso = '0;
    @(negedge clk);
    cs_n_a = 1'b0;
    if (coin) begin
      k = 0;
      @(negedge clk);
      @(negedge clk);
      tx_data_a  = cw;
      tx_valid_a = 1'b1;
      while (tx_ready_a !== 1'b1 && k < 20) begin @(negedge clk); k++; end
      n_checks++;
      if (k >= 20) begin n_fails++; $display("FAIL coin_handshake: tx_ready %b, required 1", tx_ready_a); end
      @(negedge clk);
      tx_valid_a = 1'b0;
    end
    repeat (8) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      sdo_a = mosi[9-i];
      repeat (8) @(negedge clk);
      miso[9-i] = sdi_a;
      sck_a = 1'b1;
      repeat (8) @(negedge clk);
      sck_a = 1'b0;
    end
    repeat (8) @(negedge clk);
    if (rst_mid) begin
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
    end
    cs_n_a = 1'b1;
    sdo_a  = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  // Mode-3 LSB-first master: data changes on sck fall, sampled before sck rise.
  task automatic frame_b(input logic [15:0] mosi, output logic [15:0] miso);
    miso = '0;
    @(negedge clk);
    cs_n_b = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      sck_b = 1'b0;
      sdo_b = mosi[i];
      repeat (8) @(negedge clk);
      miso[i] = sdi_b;
      sck_b = 1'b1;
      repeat (8) @(negedge clk);
    end
    repeat (8) @(negedge clk);
    cs_n_b = 1'b1;
    sdo_b  = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks += 8;
    if (rx_data_a !== 10'h000)  begin n_fails++; $display("FAIL reset_rx_data_a: got %h, required 000", rx_data_a); end
    if (rx_valid_a !== 1'b0)    begin n_fails++; $display("FAIL reset_rx_valid_a: got %b, required 0", rx_valid_a); end
    if (tx_ready_a !== 1'b1)    begin n_fails++; $display("FAIL reset_tx_ready_a: got %b, required 1", tx_ready_a); end
    if (sdi_a !== 1'b0)         begin n_fails++; $display("FAIL reset_sdi_a: got %b, required 0", sdi_a); end
    if (frame_err_a !== 1'b0)   begin n_fails++; $display("FAIL reset_frame_err_a: got %b, required 0", frame_err_a); end
    if (underrun_a !== 1'b0)    begin n_fails++; $display("FAIL reset_underrun_a: got %b, required 0", underrun_a); end
    if (tx_ready_b !== 1'b1)    begin n_fails++; $display("FAIL reset_tx_ready_b: got %b, required 1", tx_ready_b); end
    if (rx_data_b !== 16'h0000) begin n_fails++; $display("FAIL reset_rx_data_b: got %h, required 0000", rx_data_b); end
  endtask

  task automatic test_mode0_basic();
    logic [9:0] miso;
    int r0, u0;
    load_a(10'h1C3);
    n_checks++;
    if (tx_ready_a !== 1'b0) begin n_fails++; $display("FAIL basic_hold_full: tx_ready %b, required 0", tx_ready_a); end
    r0 = rxv_a; u0 = urun_a;
    exp_a.push_back(10'h2A5);
    frame_a(10'h2A5, 10, 1'b0, 10'h000, 1'b0, miso);
    n_checks += 5;
    if (miso !== 10'h1C3)      begin n_fails++; $display("FAIL basic_miso: got %h, required 1C3", miso); end
    if (rxv_a - r0 !== 1)      begin n_fails++; $display("FAIL basic_rx_pulses: got %0d, required 1", rxv_a - r0); end
    if (rx_data_a !== 10'h2A5) begin n_fails++; $display("FAIL basic_rx_data: got %h, required 2A5", rx_data_a); end
    if (urun_a !== u0)         begin n_fails++; $display("FAIL basic_underrun: got %0d pulses, required 0", urun_a - u0); end
    if (tx_ready_a !== 1'b1)   begin n_fails++; $display("FAIL basic_hold_empty: tx_ready %b, required 1", tx_ready_a); end
  endtask

  task automatic test_mode3_lsb();
    logic [15:0] miso;
    int r0, u0;
    load_b(16'h1234);
    r0 = rxv_b; u0 = urun_b;
    exp_b.push_back(16'hBEEF);
    frame_b(16'hBEEF, miso);
    n_checks += 4;
    if (miso !== 16'h1234)      begin n_fails++; $display("FAIL mode3_miso: got %h, required 1234", miso); end
    if (rx_data_b !== 16'hBEEF) begin n_fails++; $display("FAIL mode3_rx_data: got %h, required BEEF", rx_data_b); end
    if (rxv_b - r0 !== 1)       begin n_fails++; $display("FAIL mode3_rx_pulses: got %0d, required 1", rxv_b - r0); end
    if (urun_b !== u0)          begin n_fails++; $display("FAIL mode3_underrun: got %0d pulses, required 0", urun_b - u0); end
  endtask

  task automatic test_abort();
    logic [9:0] miso, w;
    int r0, f0, u0;
    w = 10'h0F0;
    load_a(w);
    r0 = rxv_a; f0 = ferr_a; u0 = urun_a;
    frame_a(10'h3C3, 6, 1'b0, 10'h000, 1'b0, miso);
    n_checks += 5;
    if (ferr_a - f0 !== 1)     begin n_fails++; $display("FAIL abort_frame_err: got %0d pulses, required 1", ferr_a - f0); end
    if (rxv_a !== r0)          begin n_fails++; $display("FAIL abort_rx_valid: got %0d pulses, required 0", rxv_a - r0); end
    if (rx_data_a !== 10'h2A5) begin n_fails++; $display("FAIL abort_rx_data: got %h, required 2A5", rx_data_a); end
    if (urun_a !== u0)         begin n_fails++; $display("FAIL abort_underrun: got %0d pulses, required 0", urun_a - u0); end
    if (miso[9:4] !== w[9:4])  begin n_fails++; $display("FAIL abort_miso: got %h, required %h", miso[9:4], w[9:4]); end
  endtask

  task automatic test_underrun();
    logic [9:0] miso;
    int r0, u0;
    r0 = rxv_a; u0 = urun_a;
    exp_a.push_back(10'h155);
    frame_a(10'h155, 10, 1'b0, 10'h000, 1'b0, miso);
    n_checks += 4;
    if (miso !== 10'h000)      begin n_fails++; $display("FAIL underrun_miso: got %h, required 000", miso); end
    if (urun_a - u0 !== 1)     begin n_fails++; $display("FAIL underrun_pulse: got %0d pulses, required 1", urun_a - u0); end
    if (rx_data_a !== 10'h155) begin n_fails++; $display("FAIL underrun_rx_data: got %h, required 155", rx_data_a); end
    if (rxv_a - r0 !== 1)      begin n_fails++; $display("FAIL underrun_rx_pulses: got %0d, required 1", rxv_a - r0); end
  endtask

  task automatic test_back_to_back();
    logic [9:0] miso;
    int u0;
    // Holding register full at frame start: old word goes out, new word waits.
    load_a(10'h0AA);
    u0 = urun_a;
    exp_a.push_back(10'h111);
    frame_a(10'h111, 10, 1'b1, 10'h2CC, 1'b0, miso);
    n_checks += 3;
    if (miso !== 10'h0AA)    begin n_fails++; $display("FAIL b2b_first_miso: got %h, required 0AA", miso); end
    if (urun_a !== u0)       begin n_fails++; $display("FAIL b2b_first_underrun: got %0d pulses, required 0", urun_a - u0); end
    if (tx_ready_a !== 1'b0) begin n_fails++; $display("FAIL b2b_new_word_held: tx_ready %b, required 0", tx_ready_a); end
    exp_a.push_back(10'h222);
    frame_a(10'h222, 10, 1'b0, 10'h000, 1'b0, miso);
    n_checks += 2;
    if (miso !== 10'h2CC)    begin n_fails++; $display("FAIL b2b_second_miso: got %h, required 2CC", miso); end
    if (tx_ready_a !== 1'b1) begin n_fails++; $display("FAIL b2b_second_empty: tx_ready %b, required 1", tx_ready_a); end
    // Holding register empty at frame start: underrun, the coincident word is kept.
    u0 = urun_a;
    exp_a.push_back(10'h333);
    frame_a(10'h333, 10, 1'b1, 10'h19B, 1'b0, miso);
    n_checks += 3;
    if (miso !== 10'h000)    begin n_fails++; $display("FAIL b2b_coin_empty_miso: got %h, required 000", miso); end
    if (urun_a - u0 !== 1)   begin n_fails++; $display("FAIL b2b_coin_empty_underrun: got %0d pulses, required 1", urun_a - u0); end
    if (tx_ready_a !== 1'b0) begin n_fails++; $display("FAIL b2b_coin_empty_held: tx_ready %b, required 0", tx_ready_a); end
    exp_a.push_back(10'h044);
    frame_a(10'h044, 10, 1'b0, 10'h000, 1'b0, miso);
    n_checks++;
    if (miso !== 10'h19B)    begin n_fails++; $display("FAIL b2b_coin_next_miso: got %h, required 19B", miso); end
  endtask

  task automatic test_reset_midframe();
    logic [9:0] miso;
    int f0, r0, u0;
    f0 = ferr_a; r0 = rxv_a;
    frame_a(10'h3FF, 4, 1'b0, 10'h000, 1'b1, miso);
    n_checks += 4;
    if (ferr_a !== f0)         begin n_fails++; $display("FAIL rstmid_frame_err: got %0d pulses, required 0", ferr_a - f0); end
    if (rxv_a !== r0)          begin n_fails++; $display("FAIL rstmid_rx_valid: got %0d pulses, required 0", rxv_a - r0); end
    if (rx_data_a !== 10'h000) begin n_fails++; $display("FAIL rstmid_rx_data: got %h, required 000", rx_data_a); end
    if (tx_ready_a !== 1'b1)   begin n_fails++; $display("FAIL rstmid_tx_ready: got %b, required 1", tx_ready_a); end
    f0 = ferr_a; r0 = rxv_a; u0 = urun_a;
    exp_a.push_back(10'h3FF);
    frame_a(10'h3FF, 10, 1'b0, 10'h000, 1'b0, miso);
    n_checks += 4;
    if (rx_data_a !== 10'h3FF) begin n_fails++; $display("FAIL rstmid_full_rx_data: got %h, required 3FF", rx_data_a); end
    if (rxv_a - r0 !== 1)      begin n_fails++; $display("FAIL rstmid_full_rx_pulses: got %0d, required 1", rxv_a - r0); end
    if (ferr_a !== f0)         begin n_fails++; $display("FAIL rstmid_full_frame_err: got %0d pulses, required 0", ferr_a - f0); end
    if (urun_a - u0 !== 1)     begin n_fails++; $display("FAIL rstmid_full_underrun: got %0d pulses, required 1", urun_a - u0); end
  endtask

  initial begin
    reset = 1'b1;
    sck_a = 1'b0; cs_n_a = 1'b1; sdo_a = 1'b0; tx_valid_a = 1'b0; tx_data_a = '0;
    sck_b = 1'b1; cs_n_b = 1'b1; sdo_b = 1'b0; tx_valid_b = 1'b0; tx_data_b = '0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    test_reset();
    test_mode0_basic();
    test_mode3_lsb();
    test_abort();
    test_underrun();
    test_back_to_back();
    test_reset_midframe();

    n_checks += 2;
    if (exp_a.size() != 0) begin n_fails++; $display("FAIL sb_a_leftover: %0d words never received, required 0", exp_a.size()); end
    if (exp_b.size() != 0) begin n_fails++; $display("FAIL sb_b_leftover: %0d words never received, required 0", exp_b.size()); end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
